// File: rtl/pwm_gen_pkg.sv
// Shared types and constants for the PWM output stage.
package pwm_gen_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    DEADTIME = 2'd2
  } state_t;

  // Last value of the 8-bit period counter; a period is 255 ticks.
  localparam logic [7:0] PERIOD_MAX = 8'd254;

  localparam int DEF_CLK_DIV      = 8;
  localparam int DEF_DEAD_PERIODS = 2;

endpackage

// File: rtl/pwm_gen_if.sv
// Request/response bundle between the angle controller and the PWM stage.
interface pwm_gen_if;
  logic       pwm_enable;
  logic [7:0] pwm_ratio;
  logic       pwm_direction;
  logic       pwm_update;
  logic       pwm_done;
  logic       busy;

  modport master (
    output pwm_enable, pwm_ratio, pwm_direction, pwm_update,
    input  pwm_done, busy
  );

  modport slave (
    input  pwm_enable, pwm_ratio, pwm_direction, pwm_update,
    output pwm_done, busy
  );
endinterface

// File: rtl/pwm_tick_gen.sv
// Prescaler: one-cycle tick every CLK_DIV enabled clocks; clr restarts at 0.
module pwm_tick_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;

  // Free-running divider, held at zero while cleared.
  always_ff @(posedge clock) begin
    if (!reset_n || clr)  presc <= '0;
    else if (en)          presc <= (presc == LAST) ? '0 : presc + 1'b1;
  end

  assign tick = en && (presc == LAST);
endmodule

// File: rtl/pwm_gen.sv
// PWM stage: boundary-aligned ratio updates and dead-time on direction flips.
module pwm_gen
  import pwm_gen_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int DEAD_PERIODS = DEF_DEAD_PERIODS
) (
  input  logic  clock,
  input  logic  reset_n,
  pwm_gen_if.slave bus,
  output logic  pwm_out,
  output logic  dir_out
);
  localparam int DW = $clog2(DEAD_PERIODS + 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_PERIODS - 1);

  state_t        state, state_nxt;
  logic [7:0]    cnt;
  logic [7:0]    active_ratio;
  logic          pend, pend_dir;
  logic [7:0]    pend_ratio;
  logic [DW-1:0] dead_cnt;
  logic          enable, tick, boundary;
  logic          apply, dead_clr, dead_inc;

  assign enable   = bus.pwm_enable;
  assign boundary = tick && (cnt == PERIOD_MAX);
  assign bus.busy = pend | (state == DEADTIME);

  pwm_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock  (clock),
    .reset_n(reset_n),
    .en     ((state != IDLE) && enable),
    .clr    ((state == IDLE) || !enable),
    .tick   (tick)
  );

  // Next state and apply decision; the H-bridge never sees an instant reversal.
  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    dead_clr  = 1'b0;
    dead_inc  = 1'b0;
    case (state)
      IDLE: begin
        // Output is already off, so a pending request can load at once.
        if (enable) begin
          state_nxt = RUN;
          apply     = pend;
        end
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (boundary && pend) begin
          if (pend_dir == dir_out) begin
            apply = 1'b1;
          end else begin
            state_nxt = DEADTIME;
            dead_clr  = 1'b1;
          end
        end
      end
      DEADTIME: begin
        // Aborting keeps pend so the request lands on re-enable.
        if (!enable) begin
          state_nxt = IDLE;
        end else if (boundary) begin
          if (dead_cnt == DEAD_LAST) begin
            apply     = 1'b1;
            state_nxt = RUN;
          end else begin
            dead_inc = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Period counter: held at 0 when idle, wraps 254 -> 0 on tick.
  always_ff @(posedge clock) begin
    if (!reset_n)                                cnt <= 8'd0;
    else if (state == IDLE || state_nxt == IDLE) cnt <= 8'd0;
    else if (tick)                               cnt <= (cnt == PERIOD_MAX) ? 8'd0 : cnt + 8'd1;
  end

  // Request buffer: last update wins; an update beats a same-cycle apply.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pend       <= 1'b0;
      pend_ratio <= 8'd0;
      pend_dir   <= 1'b0;
    end else if (bus.pwm_update) begin
      pend       <= 1'b1;
      pend_ratio <= bus.pwm_ratio;
      pend_dir   <= bus.pwm_direction;
    end else if (apply) begin
      pend <= 1'b0;
    end
  end

  // Active settings and done pulse load together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      active_ratio <= 8'd0;
      dir_out      <= 1'b0;
      bus.pwm_done <= 1'b0;
    end else begin
      bus.pwm_done <= apply;
      if (apply) begin
        active_ratio <= pend_ratio;
        dir_out      <= pend_dir;
      end
    end
  end

  // Dead-time boundary counter.
  always_ff @(posedge clock) begin
    if (!reset_n)      dead_cnt <= '0;
    else if (dead_clr) dead_cnt <= '0;
    else if (dead_inc) dead_cnt <= dead_cnt + 1'b1;
  end

  // Registered comparator output; forced low outside RUN or when enable drops.
  always_ff @(posedge clock) begin
    if (!reset_n) pwm_out <= 1'b0;
    else          pwm_out <= (state == RUN) && enable && (cnt < active_ratio);
  end
endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen with CLK_DIV=2, DEAD_PERIODS=1 (510-clock period).
module tb_pwm_gen;
  localparam int CD  = 2;
  localparam int DP  = 1;
  localparam int PER = 255 * CD;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic pwm_out, dir_out;
  int   cyc = 0;
  int   checks = 0, failures = 0;
  int   base = 0;

  pwm_gen_if bus();

  pwm_gen #(.CLK_DIV(CD), .DEAD_PERIODS(DP)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus),
    .pwm_out(pwm_out),
    .dir_out(dir_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input logic [7:0] r, input logic d);
    bus.pwm_ratio     = r;
    bus.pwm_direction = d;
    bus.pwm_update    = 1'b1;
    step();
    bus.pwm_update    = 1'b0;
  endtask

  // First boundary edge strictly after edge s, counted from the enable edge.
  function automatic int next_bnd(input int s);
    return base + PER * ((s - base) / PER + 1);
  endfunction

  task automatic wait_done(input string tag, input int exp);
    int n = 0;
    while (!bus.pwm_done && n < 3 * PER) begin
      step();
      n++;
    end
    chk(tag, cyc, exp);
  endtask

  task automatic run_to(input string tag, input int target);
    int dn = 0;
    while (cyc < target) begin
      step();
      if (bus.pwm_done) dn++;
    end
    chk(tag, dn, 0);
  endtask

  task automatic measure(input int n, output int hi, output int edg, output int dn, output int dh);
    logic prev;
    hi = 0; edg = 0; dn = 0; dh = 0; prev = 1'b0;
    for (int j = 0; j < n; j++) begin
      step();
      if (pwm_out) hi++;
      if (j > 0 && pwm_out !== prev) edg++;
      prev = pwm_out;
      if (bus.pwm_done) dn++;
      if (dir_out) dh++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi, edg, dn, dh, bd, exp;
    bus.pwm_enable = 1'b0; bus.pwm_update = 1'b0;
    bus.pwm_ratio = 8'd0;  bus.pwm_direction = 1'b0;

    // 1: reset with update pulsing
    for (int i = 0; i < 3; i++) begin
      bus.pwm_update = (i != 1); bus.pwm_ratio = 8'd77; bus.pwm_direction = 1'b1;
      step();
      chk("rst_pwm_out", pwm_out, 0);
      chk("rst_dir_out", dir_out, 0);
      chk("rst_done", bus.pwm_done, 0);
      chk("rst_busy", bus.busy, 0);
    end
    bus.pwm_update = 1'b0;
    reset_n = 1'b1;
    measure(3, hi, edg, dn, dh);
    chk("post_rst_done", dn, 0);
    chk("post_rst_busy", bus.busy, 0);

    // 2: enable + ratio 128, dir 0
    bus.pwm_enable = 1'b1;
    request(8'd128, 1'b0);
    base = cyc;
    chk("t2_busy", bus.busy, 1);
    wait_done("t2_done_cycle", base + PER);
    chk("t2_dir", dir_out, 0);
    chk("t2_busy_after", bus.busy, 0);
    for (int p = 0; p < 2; p++) begin
      measure(PER, hi, edg, dn, dh);
      chk("t2_high", hi, 256);
      chk("t2_edges", edg, 1);
      chk("t2_no_done", dn, 0);
    end

    // 3: ratio 0, then ratio 255 issued on a boundary cycle
    request(8'd0, 1'b0);
    exp = next_bnd(cyc);
    wait_done("t3_zero_done", exp);
    measure(PER - 1, hi, edg, dn, dh);
    chk("t3_zero_high", hi, 0);
    chk("t3_zero_edges", edg, 0);
    request(8'd255, 1'b0);
    chk("t3_bnd_upd_edge", cyc, exp + PER);
    wait_done("t3_bnd_upd_done", exp + 2 * PER);
    measure(PER, hi, edg, dn, dh);
    chk("t3_full_high", hi, PER);
    chk("t3_full_edges", edg, 0);

    // 4: reversal with dead-time
    request(8'd128, 1'b0);
    wait_done("t4_pre_done", next_bnd(cyc));
    measure(PER, hi, edg, dn, dh);
    chk("t4_pre_high", hi, 256);
    request(8'd64, 1'b1);
    bd = next_bnd(cyc);
    run_to("t4_no_early_done", bd);
    chk("t4_dead_busy", bus.busy, 1);
    measure(PER - 1, hi, edg, dn, dh);
    chk("t4_dead_high", hi, 0);
    chk("t4_dead_dir", dh, 0);
    chk("t4_dead_done", dn, 0);
    wait_done("t4_done_cycle", bd + PER);
    chk("t4_dir_new", dir_out, 1);
    chk("t4_pwm_at_done", pwm_out, 0);
    chk("t4_busy_clear", bus.busy, 0);
    measure(PER, hi, edg, dn, dh);
    chk("t4_high", hi, 128);
    chk("t4_edges", edg, 1);
    chk("t4_no_done", dn, 0);

    // 5: two updates in one period merge
    request(8'd100, 1'b1);
    repeat (20) step();
    request(8'd200, 1'b1);
    wait_done("t5_done_cycle", next_bnd(cyc));
    measure(PER, hi, edg, dn, dh);
    chk("t5_high", hi, 400);
    chk("t5_no_done", dn, 0);

    // 6a: enable drop while output high in RUN
    repeat (10) step();
    chk("t6_run_high", pwm_out, 1);
    bus.pwm_enable = 1'b0;
    step();
    chk("t6_run_drop_low", pwm_out, 0);
    repeat (3) step();
    bus.pwm_enable = 1'b1;
    step();
    base = cyc;
    chk("t6_reen_no_done", bus.pwm_done, 0);

    // 6b: enable drop at cnt=50 in dead-time, then re-enable
    bus.pwm_ratio = 8'd64; bus.pwm_direction = 1'b0; bus.pwm_update = 1'b1;
    step();
    bus.pwm_update = 1'b0;
    bd = next_bnd(cyc);
    run_to("t6_no_early_done", bd);
    repeat (100) step();
    bus.pwm_enable = 1'b0;
    step();
    chk("t6_abort_pwm", pwm_out, 0);
    chk("t6_abort_busy", bus.busy, 1);
    chk("t6_abort_dir", dir_out, 1);
    measure(5, hi, edg, dn, dh);
    chk("t6_idle_done", dn, 0);
    chk("t6_idle_high", hi, 0);
    bus.pwm_enable = 1'b1;
    step();
    base = cyc;
    chk("t6_apply_done", bus.pwm_done, 1);
    chk("t6_apply_dir", dir_out, 0);
    chk("t6_apply_busy", bus.busy, 0);
    step();
    chk("t6_done_single", bus.pwm_done, 0);
    measure(PER - 1, hi, edg, dn, dh);
    chk("t6_high", hi, 127);
    chk("t6_no_done", dn, 0);

    // 7: reset during dead-time discards the request
    request(8'd255, 1'b1);
    bd = next_bnd(cyc);
    run_to("t7_no_early_done", bd);
    repeat (30) step();
    chk("t7_dead_busy", bus.busy, 1);
    reset_n = 1'b0;
    step();
    chk("t7_rst_pwm", pwm_out, 0);
    chk("t7_rst_dir", dir_out, 0);
    chk("t7_rst_busy", bus.busy, 0);
    chk("t7_rst_done", bus.pwm_done, 0);
    reset_n = 1'b1;
    measure(PER + 100, hi, edg, dn, dh);
    chk("t7_after_done", dn, 0);
    chk("t7_after_high", hi, 0);
    chk("t7_after_dir", dh, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
